// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell is time-shared across WIDTH cycles,
// operands shift LSB-first and the finished result is held until the next add.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);
  localparam int CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aShift_q, aShift_d;
  logic [WIDTH-1:0] bShift_q, bShift_d;
  logic [WIDTH-1:0] resShift_q, resShift_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             faSum, faCout;
  logic [WIDTH-1:0] resNext;

  full_adder uFullAdder (
    .a_i   (aShift_q[0]),
    .b_i   (bShift_q[0]),
    .cin_i (carry_q),
    .sum_o (faSum),
    .cout_o(faCout)
  );

  // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  generate
    if (WIDTH == 1) begin : gNarrow
      assign resNext = faSum;
    end else begin : gWide
      assign resNext = {faSum, resShift_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    aShift_d   = aShift_q;
    bShift_d   = bShift_q;
    resShift_d = resShift_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cout_d     = cout_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          aShift_d   = a_i;
          bShift_d   = b_i;
          carry_d    = cin_i;
          resShift_d = '0;
          cnt_d      = '0;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Abort wins even on the final bit, so a cancelled add never publishes.
        if (abort_i) begin
          state_d = IDLE;
        end else begin
          aShift_d   = aShift_q >> 1;
          bShift_d   = bShift_q >> 1;
          resShift_d = resNext;
          carry_d    = faCout;
          cnt_d      = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            sum_d   = resNext;
            cout_d  = faCout;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      aShift_q   <= '0;
      bShift_q   <= '0;
      resShift_q <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cout_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      aShift_q   <= aShift_d;
      bShift_q   <= bShift_d;
      resShift_q <= resShift_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cout_q     <= cout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ready_o = (state_q != SHIFT);
  assign busy_o  = (state_q == SHIFT);
  assign done_o  = (state_q == DONE);
  assign sum_o   = sum_q;
  assign cout_o  = cout_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit and a 1-bit instance
// are checked against plain integer addition of the captured operands.

module tb_serial_adder_ctrl;
  logic       clk;
  logic       rst_n;

  logic       start8, abort8, cin8;
  logic [7:0] a8, b8;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1, abort1, cin1;
  logic [0:0] a1, b1;
  logic       ready1, busy1, done1, cout1;
  logic [0:0] sum1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
  } vec_t;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .abort_i(abort8),
    .a_i(a8), .b_i(b8), .cin_i(cin8), .ready_o(ready8), .busy_o(busy8),
    .done_o(done8), .sum_o(sum8), .cout_o(cout8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1),
    .a_i(a1), .b_i(b1), .cin_i(cin1), .ready_o(ready1), .busy_o(busy1),
    .done_o(done1), .sum_o(sum1), .cout_o(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts one 8-bit add and waits (bounded) for done; operands are scrambled
  // after the accepting edge to prove they were captured.
  task automatic applyStimulus8(input logic [7:0] a, input logic [7:0] b, input logic c,
                                output logic [7:0] s, output logic co, output int lat);
    logic [7:0] prevSum;
    logic       held;
    prevSum = sum8;
    held    = 1'b1;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    checkOutput("busy after start", busy8, 1);
    checkOutput("ready low in shift", ready8, 0);
    lat = 0;
    while (!done8 && lat < 40) begin
      if (sum8 !== prevSum) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    checkOutput("sum held during shift", held, 1);
    s  = sum8;
    co = cout8;
  endtask

  task automatic applyStimulus1(input logic a, input logic b, input logic c,
                                output logic s, output logic co, output int lat);
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    lat = 0;
    while (!done1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    s  = sum1[0];
    co = cout1;
  endtask

  initial begin
    vec_t       vecs[5];
    logic [7:0] s;
    logic       co;
    logic       s1, co1;
    logic [8:0] model;
    logic [1:0] model1;
    int         lat;
    int         gap;
    logic       sawDone;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b0};

    rst_n = 1'b0;
    start8 = 0; abort8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; abort1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    #3;
    checkOutput("reset sum", sum8, 0);
    checkOutput("reset cout", cout8, 0);
    checkOutput("reset ready", ready8, 1);
    checkOutput("reset busy", busy8, 0);
    checkOutput("reset done", done8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus8(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat);
      checkOutput($sformatf("vec%0d sum", i), s, vecs[i].expSum);
      checkOutput($sformatf("vec%0d cout", i), co, vecs[i].expCout);
      checkOutput($sformatf("vec%0d latency", i), lat, 8);
      @(negedge clk);
      checkOutput($sformatf("vec%0d done width", i), done8, 0);
      checkOutput($sformatf("vec%0d ready after", i), ready8, 1);
    end

    // Start pulsed three cycles into SHIFT with different operands.
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      if (lat == 3) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0;
    checkOutput("ignored start sum", sum8, 8'h47);
    checkOutput("ignored start cout", cout8, 0);
    checkOutput("ignored start latency", lat, 8);
    @(negedge clk);

    // Abort at cycle 4 must leave the previous result intact.
    a8 = 8'h33; b8 = 8'h44; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    checkOutput("abort ready", ready8, 1);
    checkOutput("abort busy", busy8, 0);
    sawDone = 1'b0;
    repeat (12) begin
      if (done8) sawDone = 1'b1;
      @(negedge clk);
    end
    checkOutput("abort no done", sawDone, 0);
    checkOutput("abort sum kept", sum8, 8'h47);
    checkOutput("abort cout kept", cout8, 0);

    // Back-to-back: second start (with a simultaneous abort) during done.
    applyStimulus8(8'h10, 8'h20, 1'b0, s, co, lat);
    checkOutput("b2b first sum", s, 8'h30);
    checkOutput("b2b first cout", co, 0);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; start8 = 1'b1; abort8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0; abort8 = 1'b0;
    checkOutput("b2b second accepted", busy8, 1);
    gap = 1;
    while (!done8 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    checkOutput("b2b done spacing", gap, 9);
    checkOutput("b2b second sum", sum8, 8'h00);
    checkOutput("b2b second cout", cout8, 1);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      model = 9'(ra) + 9'(rb) + 9'(rc);
      applyStimulus8(ra, rb, rc, s, co, lat);
      checkOutput($sformatf("rand%0d result", i), {co, s}, model);
      checkOutput($sformatf("rand%0d latency", i), lat, 8);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a shift.
    applyStimulus8(8'h01, 8'h01, 1'b0, s, co, lat);
    checkOutput("pre-reset sum", s, 8'h02);
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset sum", sum8, 0);
    checkOutput("async reset cout", cout8, 0);
    checkOutput("async reset ready", ready8, 1);
    checkOutput("async reset busy", busy8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) sawDone = 1'b1;
    end
    checkOutput("no done after reset", sawDone, 0);
    checkOutput("idle after reset", ready8, 1);

    for (int i = 0; i < 8; i++) begin
      logic ea, eb, ec;
      ea = i[2]; eb = i[1]; ec = i[0];
      model1 = 2'(ea) + 2'(eb) + 2'(ec);
      applyStimulus1(ea, eb, ec, s1, co1, lat);
      checkOutput($sformatf("w1 case%0d result", i), {co1, s1}, model1);
      checkOutput($sformatf("w1 case%0d latency", i), lat, 1);
      @(negedge clk);
      checkOutput($sformatf("w1 case%0d done width", i), done1, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that time-shares one instance of the team's `full_adder` cell to add two WIDTH-bit operands over WIDTH clock cycles. Inputs are captured with a start/ready handshake, the operands are shifted LSB-first through the cell with a registered carry, and the result is held in an output register until the next completed operation. It sits beside the combinational library as the area-minimal alternative to a WIDTH-bit ripple adder.

## Interface
- `WIDTH`, default 8: operand and result width. Legal range is WIDTH >= 1.
- `clk`  in  1  system clock, rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  request an operation. Sampled only when `ready`=1.
- `abort`  in  1  synchronous cancel of an in-flight operation.
- `a`  in  WIDTH  operand A, captured at the accepted start.
- `b`  in  WIDTH  operand B, captured at the accepted start.
- `cin`  in  1  carry-in, captured at the accepted start.
- `ready`  out  1  block can accept `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `sum`/`cout` updated.
- `sum`  out  WIDTH  last completed result.
- `cout`  out  1  carry-out of the last completed result.

## Operation
- **States:**
  - IDLE: `ready`=1, `busy`=0, `done`=0.
  - SHIFT: `ready`=0, `busy`=1, `done`=0.
  - DONE: `ready`=1, `busy`=0, `done`=1.
- **Reset** (`rst_n`=0, asynchronous, any state):
  - State goes to IDLE.
  - `sum`=0, `cout`=0, `done`=0, `busy`=0, `ready`=1.
  - Internal shift registers, carry flop and bit counter are cleared.
  - Reset mid-operation discards the operation; no `done` is produced.
- **IDLE or DONE with `start`=1:**
  - Load `a` and `b` into shift registers and `cin` into the carry flop.
  - Clear the counter and go to SHIFT.
  - With `start`=0, IDLE holds and DONE returns to IDLE.
- **SHIFT, each cycle:**
  - The `full_adder` instance adds A[0], B[0] and the carry flop.
  - The cell's sum bit shifts into the MSB of the result shift register; A and B shift right.
  - The carry flop takes the cell's cout and the counter increments.
  - On the cycle where the counter equals WIDTH-1: copy the result register (including that cycle's bit) to `sum`, cell cout to `cout`, and go to DONE.
- **Output relation:** at `done`, {`cout`,`sum`} = `a` + `b` + `cin` (the values captured at start), computed modulo 2^(WIDTH+1).
- **Ignored requests:** `start` during SHIFT is ignored, with no queuing.
- **Abort:**
  - `abort`=1 in SHIFT returns to IDLE on the next edge with no `done`; `sum`/`cout` keep the previous completed result.
  - `abort` in IDLE or DONE has no effect.
  - `abort` and `start` together in DONE: `start` wins.
- **WIDTH=1:** SHIFT lasts exactly one cycle.
- **Counter width:** $clog2(WIDTH)+1 bits, so WIDTH=1 is legal.

## Timing
- **Start to done:** with start accepted at edge E0, `busy`=1 after E0 through EW, and `done`=1 for the single cycle after EW. Latency is WIDTH cycles.
- **Output update:** `sum`/`cout` change only at the edge that raises `done`, and are stable for the rest of that cycle and afterwards.
- **Back-to-back:** `start` asserted during the `done` cycle is accepted at that edge, giving WIDTH+1 cycles per operation.
- **Combinational paths:** all outputs are registered. `ready`/`busy`/`done` are state decodes with no combinational path from inputs.
- **Critical path:** one `full_adder` cell plus flop setup, independent of WIDTH.

## Test plan
- **Reset:** assert `rst_n`=0 mid-SHIFT (WIDTH=8) -> outputs go immediately, without waiting for a clock edge, to `sum`=0x00, `cout`=0, `ready`=1, `busy`=0; no `done` follows after release.
- **Basic add:** WIDTH=8, a=0x5A, b=0x3C, cin=0 -> `done` exactly 8 cycles after the start edge, `sum`=0x96, `cout`=0.
- **Carry and wrap:**
  - a=0xFF, b=0x01, cin=0 -> `sum`=0x00, `cout`=1.
  - a=0xFF, b=0xFF, cin=1 -> `sum`=0xFF, `cout`=1.
- **Ignored start and abort:**
  - `start` pulsed with new operands 3 cycles into SHIFT -> ignored; the original result is delivered.
  - `abort` at cycle 4 -> IDLE, no `done`, `sum` keeps the prior value.
- **Back-to-back:** 0x10+0x20 then 0x80+0x80, second `start` held during the first `done` -> `done` pulses 9 cycles apart; results are 0x30/`cout`=0 and 0x00/`cout`=1.
- **WIDTH=1 exhaustive:** all 8 {a,b,cin} combinations -> {`cout`,`sum`} matches the full-adder truth table, and `done` follows each start after 1 cycle.
